pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage LC-3b pipeline (IF, ID, EX, MEM, WB). It drives the stall and bubble controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC load enable. It tracks a valid bit for each register's contents and counts stall and flush events for performance debug. It sits beside the datapath and takes hazard inputs from ID, EX, MEM and both caches.

---
 rtl/lc3b_types.sv | 38 +++
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: hazard sequencer states and the NOP control
// word that bubbles and flushes load into the pipeline registers.
package lc3b_types;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RECOVER  = 2'd2
    } lc3b_pipe_state;

    typedef struct packed {
        logic [3:0] opcode;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } lc3b_control_word;

    // BR with nzp=000 never branches, so an all-zero word is a true NOP
    localparam lc3b_control_word lc3b_nop_ctrl = '{
        opcode:       4'h0,
        load_regfile: 1'b0,
        load_cc:      1'b0,
        mem_read:     1'b0,
        mem_write:    1'b0,
        branch:       1'b0
    };

    function automatic logic reg_match(
        input logic       uses,
        input logic [2:0] src,
        input logic [2:0] dest
    );
        return uses & (src == dest);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance events.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline: freezes on cache
// misses, bubbles on load-use, flushes the front end on branch mispredicts.
import lc3b_types::*;

module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             icache_req,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    input  logic [2:0]       id_sr1_reg,
    input  logic [2:0]       id_sr2_reg,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_dest,
    input  logic             mispredict,
    output logic             pc_load,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             bubble_id_ex,
    output logic             flush_front,
    output logic             valid_id,
    output logic             valid_ex,
    output logic             valid_mem,
    output logic             valid_wb,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    lc3b_pipe_state state_q;
    logic pending_q;
    logic vid_q, vex_q, vmem_q, vwb_q;

    logic mem_busy;
    logic mp_eff;
    logic load_use;
    logic any_stall;

    always_comb begin
        mem_busy = (icache_req & ~icache_resp) | (dcache_req & ~dcache_resp);
        mp_eff   = mispredict & vmem_q & ~mem_busy;
        load_use = vex_q & vid_q & ex_is_load
                 & (reg_match(id_uses_sr1, id_sr1_reg, ex_dest)
                  | reg_match(id_uses_sr2, id_sr2_reg, ex_dest));

        pc_load      = 1'b1;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        bubble_id_ex = 1'b0;
        flush_front  = 1'b0;

        // Held in reset the pipeline looks empty, so controls stay idle
        if (reset) begin
            pc_load = 1'b1;
        end else if (mem_busy) begin
            pc_load      = 1'b0;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
        end else if (mp_eff) begin
            flush_front = 1'b1;
        end else if (load_use) begin
            pc_load      = 1'b0;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end

        any_stall = stall_if_id | stall_id_ex | stall_ex_mem | stall_mem_wb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
            vid_q     <= 1'b0;
            vex_q     <= 1'b0;
            vmem_q    <= 1'b0;
            vwb_q     <= 1'b0;
        end else if (mem_busy) begin
            state_q <= MEM_WAIT;
            if (state_q == RECOVER) begin
                pending_q <= 1'b1;
            end
        end else if (mp_eff) begin
            state_q   <= RECOVER;
            pending_q <= 1'b0;
            vid_q     <= 1'b0;
            vex_q     <= 1'b0;
            vmem_q    <= 1'b0;
            vwb_q     <= vmem_q;
        end else if (load_use) begin
            state_q   <= pending_q ? RECOVER : RUN;
            pending_q <= 1'b0;
            vex_q     <= 1'b0;
            vmem_q    <= vex_q;
            vwb_q     <= vmem_q;
        end else begin
            // The fetch issued during RECOVER came from the wrong path
            state_q   <= pending_q ? RECOVER : RUN;
            pending_q <= 1'b0;
            vid_q     <= (state_q != RECOVER);
            vex_q     <= vid_q;
            vmem_q    <= vex_q;
            vwb_q     <= vmem_q;
        end
    end

    assign valid_id  = vid_q;
    assign valid_ex  = vex_q;
    assign valid_mem = vmem_q;
    assign valid_wb  = vwb_q;
    assign state     = state_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (any_stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mp_eff),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: slot-occupancy model checked every cycle
// plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int SAT   = 65535;
    localparam int K_BUSY = 0, K_FLUSH = 1, K_LU = 2, K_ADV = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic icache_req, icache_resp, dcache_req, dcache_resp;
    logic [2:0] id_sr1_reg, id_sr2_reg, ex_dest;
    logic id_uses_sr1, id_uses_sr2, ex_is_load, mispredict;
    logic pc_load, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic bubble_id_ex, flush_front;
    logic valid_id, valid_ex, valid_mem, valid_wb;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    logic [3:0] stv, vv;
    assign stv = {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
    assign vv  = {valid_id, valid_ex, valid_mem, valid_wb};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .icache_req   (icache_req),
        .icache_resp  (icache_resp),
        .dcache_req   (dcache_req),
        .dcache_resp  (dcache_resp),
        .id_sr1_reg   (id_sr1_reg),
        .id_sr2_reg   (id_sr2_reg),
        .id_uses_sr1  (id_uses_sr1),
        .id_uses_sr2  (id_uses_sr2),
        .ex_is_load   (ex_is_load),
        .ex_dest      (ex_dest),
        .mispredict   (mispredict),
        .pc_load      (pc_load),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .bubble_id_ex (bubble_id_ex),
        .flush_front  (flush_front),
        .valid_id     (valid_id),
        .valid_ex     (valid_ex),
        .valid_mem    (valid_mem),
        .valid_wb     (valid_wb),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: occupancy of slots ID,EX,MEM,WB (index 0..3), mode, counters
    bit mv[4];
    int m_st;
    bit m_pend;
    int m_stall, m_flush;

    function automatic int classify();
        bit busy;
        bit hit;
        busy = (icache_req && !icache_resp) || (dcache_req && !dcache_resp);
        hit  = (id_uses_sr1 && id_sr1_reg == ex_dest)
            || (id_uses_sr2 && id_sr2_reg == ex_dest);
        if (busy) return K_BUSY;
        if (mispredict && mv[2]) return K_FLUSH;
        if (mv[0] && mv[1] && ex_is_load && hit) return K_LU;
        return K_ADV;
    endfunction

    function automatic int mvec();
        return int'({mv[0], mv[1], mv[2], mv[3]});
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit nv[4];
        int k;
        if (reset) begin
            mv      <= '{default: 1'b0};
            m_st    <= 0;
            m_pend  <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            k  = classify();
            nv = mv;
            case (k)
                K_BUSY: begin
                    if (m_st == 2) m_pend <= 1'b1;
                    m_st <= 1;
                    if (m_stall < SAT) m_stall <= m_stall + 1;
                end
                K_FLUSH: begin
                    nv = '{1'b0, 1'b0, 1'b0, mv[2]};
                    m_st   <= 2;
                    m_pend <= 1'b0;
                    if (m_flush < SAT) m_flush <= m_flush + 1;
                end
                K_LU: begin
                    nv = '{mv[0], 1'b0, mv[1], mv[2]};
                    m_st   <= m_pend ? 2 : 0;
                    m_pend <= 1'b0;
                    if (m_stall < SAT) m_stall <= m_stall + 1;
                end
                default: begin
                    nv = '{(m_st != 2), mv[0], mv[1], mv[2]};
                    m_st   <= m_pend ? 2 : 0;
                    m_pend <= 1'b0;
                end
            endcase
            mv <= nv;
        end
    end

    always @(negedge clk) begin
        int k;
        if (!reset) begin
            k = classify();
            chk("pc_load", int'(pc_load), int'(k == K_ADV || k == K_FLUSH));
            chk("stalls", int'(stv),
                (k == K_BUSY) ? 15 : (k == K_LU) ? 8 : 0);
            chk("bubble", int'(bubble_id_ex), int'(k == K_LU));
            chk("flush", int'(flush_front), int'(k == K_FLUSH));
            chk("valids", int'(vv), mvec());
            chk("state", int'(state), m_st);
            chk("stall_cycles", int'(stall_cycles), m_stall);
            chk("flush_count", int'(flush_count), m_flush);
        end
    end

    task automatic idle();
        icache_req  = 1'b1;
        icache_resp = 1'b1;
        dcache_req  = 1'b0;
        dcache_resp = 1'b0;
        id_sr1_reg  = 3'd0;
        id_sr2_reg  = 3'd0;
        id_uses_sr1 = 1'b0;
        id_uses_sr2 = 1'b0;
        ex_is_load  = 1'b0;
        ex_dest     = 3'd7;
        mispredict  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        int n_mw;
        int n_st;
        idle();
        dcache_req = 1'b1;
        reset = 1'b1;
        #12;
        chk("rst_pc_load", int'(pc_load), 1);
        chk("rst_stalls", int'(stv), 0);
        chk("rst_bubble_flush", int'({bubble_id_ex, flush_front}), 0);
        chk("rst_valids", int'(vv), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_counters", int'({stall_cycles, flush_count}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        for (int i = 0; i < 5; i++) begin
            settle();
            chk("fill_pc_load", int'(pc_load), 1);
            if (i == 4) chk("fill_valids", int'(vv), 15);
            tick();
        end

        ex_is_load  = 1'b1;
        ex_dest     = 3'd2;
        id_sr1_reg  = 3'd2;
        id_uses_sr1 = 1'b1;
        settle();
        chk("lu_stall_if_id", int'(stall_if_id), 1);
        chk("lu_bubble", int'(bubble_id_ex), 1);
        chk("lu_pc_load", int'(pc_load), 0);
        chk("lu_back_stalls", int'(stv[1:0]), 0);
        tick();
        idle();
        settle();
        chk("lu_valids", int'(vv), 4'hB);
        chk("lu_stall_cycles", int'(stall_cycles), 1);
        repeat (3) tick();
        settle();
        chk("refill_valids", int'(vv), 15);

        n_mw = 0;
        n_st = 0;
        for (int k = 0; k < 4; k++) begin
            dcache_req  = 1'b1;
            dcache_resp = (k == 3);
            settle();
            if (state == 2'd1) n_mw++;
            if (stv == 4'hF && !pc_load) n_st++;
            tick();
        end
        idle();
        settle();
        chk("dc_memwait_cycles", n_mw, 3);
        chk("dc_stall_cycles_seen", n_st, 3);
        chk("dc_stall_cycles", int'(stall_cycles), 4);
        chk("dc_valids", int'(vv), 15);
        chk("dc_state", int'(state), 0);

        mispredict = 1'b1;
        settle();
        chk("mp_flush", int'(flush_front), 1);
        chk("mp_pc_load", int'(pc_load), 1);
        chk("mp_stalls", int'(stv), 0);
        tick();
        mispredict = 1'b0;
        settle();
        chk("mp_valids", int'(vv), 1);
        chk("mp_state", int'(state), 2);
        chk("mp_flush_count", int'(flush_count), 1);
        tick();
        settle();
        chk("rec_valids", int'(vv), 0);
        chk("rec_state", int'(state), 0);

        mispredict = 1'b1;
        settle();
        chk("mp_ignored_flush", int'(flush_front), 0);
        tick();
        mispredict = 1'b0;
        settle();
        chk("mp_ignored_count", int'(flush_count), 1);
        chk("mp_ignored_valids", int'(vv), 8);
        tick();
        tick();

        mispredict  = 1'b1;
        ex_is_load  = 1'b1;
        ex_dest     = 3'd5;
        id_sr2_reg  = 3'd5;
        id_uses_sr2 = 1'b1;
        settle();
        chk("mplu_flush", int'(flush_front), 1);
        chk("mplu_bubble", int'(bubble_id_ex), 0);
        chk("mplu_stall_if_id", int'(stall_if_id), 0);
        tick();
        idle();
        icache_resp = 1'b0;
        settle();
        chk("mplu_flush_count", int'(flush_count), 2);
        chk("rec_busy_stalls", int'(stv), 15);
        tick();
        settle();
        chk("rec_busy_state", int'(state), 1);
        tick();
        icache_resp = 1'b1;
        settle();
        chk("rec_exit_state", int'(state), 1);
        tick();
        settle();
        chk("rec_pending_state", int'(state), 2);
        tick();

        dcache_req = 1'b1;
        tick();
        chk("arst_pre_state", int'(state), 1);
        reset = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_valids", int'(vv), 0);
        chk("arst_stalls", int'(stv), 0);
        chk("arst_pc_load", int'(pc_load), 1);
        chk("arst_flush_count", int'(flush_count), 0);
        tick();
        reset = 1'b0;
        idle();

        icache_resp = 1'b0;
        repeat (65541) tick();
        icache_resp = 1'b1;
        settle();
        chk("sat_stall_cycles", int'(stall_cycles), 16'hFFFF);
        tick();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
